reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w_if.sv | 58 +++++
 rtl/reg_file_2r1w.sv | 159 +++++++++++++++
 tb/tb_reg_file_2r1w.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: write port, two read ports and the exposed register view.
// With RF_PARITY_EN defined, the parity-injection input and per-port parity-error flags are added.
interface reg_file_2r1w_if #(
    parameter int DSIZE   = 8,
    parameter int ASIZE   = 4,
    parameter int NEXPOSE = 4
);
    logic                       WrEn;
    logic [ASIZE-1:0]           WrAddr;
    logic [DSIZE-1:0]           WrData;
    logic [DSIZE/8-1:0]         WrStrb;
    logic                       RdEn_A;
    logic [ASIZE-1:0]           RdAddr_A;
    logic [DSIZE-1:0]           RdData_A;
    logic                       RdValid_A;
    logic                       RdErr_A;
    logic                       RdEn_B;
    logic [ASIZE-1:0]           RdAddr_B;
    logic [DSIZE-1:0]           RdData_B;
    logic                       RdValid_B;
    logic                       RdErr_B;
    logic [NEXPOSE*DSIZE-1:0]   REGS;
`ifdef RF_PARITY_EN
    logic [DSIZE/8-1:0]         ParInj;
    logic                       RdPErr_A;
    logic                       RdPErr_B;

    modport master (
        output WrEn, WrAddr, WrData, WrStrb, ParInj,
        output RdEn_A, RdAddr_A, RdEn_B, RdAddr_B,
        input  RdData_A, RdValid_A, RdErr_A, RdPErr_A,
        input  RdData_B, RdValid_B, RdErr_B, RdPErr_B,
        input  REGS
    );
    modport slave (
        input  WrEn, WrAddr, WrData, WrStrb, ParInj,
        input  RdEn_A, RdAddr_A, RdEn_B, RdAddr_B,
        output RdData_A, RdValid_A, RdErr_A, RdPErr_A,
        output RdData_B, RdValid_B, RdErr_B, RdPErr_B,
        output REGS
    );
`else
    modport master (
        output WrEn, WrAddr, WrData, WrStrb,
        output RdEn_A, RdAddr_A, RdEn_B, RdAddr_B,
        input  RdData_A, RdValid_A, RdErr_A,
        input  RdData_B, RdValid_B, RdErr_B,
        input  REGS
    );
    modport slave (
        input  WrEn, WrAddr, WrData, WrStrb,
        input  RdEn_A, RdAddr_A, RdEn_B, RdAddr_B,
        output RdData_A, RdValid_A, RdErr_A,
        output RdData_B, RdValid_B, RdErr_B,
        output REGS
    );
`endif
endinterface

// File: rtl/reg_file_2r1w.sv
// Configuration register file: one byte-strobed write port, two independent registered read ports,
// out-of-range flagging and a flat view of the low registers. RF_PARITY_EN adds per-lane even parity.
module reg_file_2r1w #(
    parameter int               DSIZE    = 8,
    parameter int               ASIZE    = 4,
    parameter int               DEPTH    = 16,
    parameter int               NEXPOSE  = 4,
    parameter logic [DSIZE-1:0] RST_VAL2 = 8'h81,
    parameter logic [DSIZE-1:0] RST_VAL3 = 8'h20
) (
    input  logic            CLK,
    input  logic            RST,
    reg_file_2r1w_if.slave  bus
);
    localparam int             NB      = DSIZE / 8;
    localparam logic [ASIZE:0] DEPTH_L = (ASIZE + 1)'(DEPTH);

    function automatic logic [DSIZE-1:0] rst_val(input int idx);
        if (idx == 2)      return RST_VAL2;
        else if (idx == 3) return RST_VAL3;
        else               return '0;
    endfunction

    function automatic logic in_range(input logic [ASIZE-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    function automatic logic [NB-1:0] lane_par(input logic [DSIZE-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int k = 0; k < NB; k++) p[k] = ^d[8*k +: 8];
        return p;
    endfunction

    logic [DSIZE-1:0]         mem_r [DEPTH];
    logic                     wr_hit_s;
    logic [DSIZE-1:0]         wr_data_s;
    logic [DSIZE-1:0]         rd_a_data_s, rd_b_data_s;
    logic [DSIZE-1:0]         rd_a_data_r, rd_b_data_r;
    logic                     rd_a_valid_r, rd_b_valid_r;
    logic                     rd_a_err_r, rd_b_err_r;
    logic [NEXPOSE*DSIZE-1:0] regs_s;

    // Write merge: unstrobed lanes keep the currently stored byte.
    always_comb begin
        wr_hit_s  = bus.WrEn && in_range(bus.WrAddr);
        wr_data_s = '0;
        if (in_range(bus.WrAddr)) begin
            wr_data_s = mem_r[bus.WrAddr];
        end else begin
            wr_data_s = '0;
        end
        for (int k = 0; k < NB; k++) begin
            if (bus.WrStrb[k]) begin
                wr_data_s[8*k +: 8] = bus.WrData[8*k +: 8];
            end else begin
                wr_data_s[8*k +: 8] = wr_data_s[8*k +: 8];
            end
        end
    end

    // Storage array; reads below see the pre-write contents of the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= rst_val(i);
        end else if (wr_hit_s) begin
            mem_r[bus.WrAddr] <= wr_data_s;
        end
    end

    // Read data selection; out-of-range addresses return zero.
    always_comb begin
        if (in_range(bus.RdAddr_A)) rd_a_data_s = mem_r[bus.RdAddr_A];
        else                        rd_a_data_s = '0;
        if (in_range(bus.RdAddr_B)) rd_b_data_s = mem_r[bus.RdAddr_B];
        else                        rd_b_data_s = '0;
    end

    // Port A output registers; data and error hold while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_a_data_r  <= '0;
            rd_a_valid_r <= 1'b0;
            rd_a_err_r   <= 1'b0;
        end else if (bus.RdEn_A) begin
            rd_a_data_r  <= rd_a_data_s;
            rd_a_valid_r <= 1'b1;
            rd_a_err_r   <= !in_range(bus.RdAddr_A);
        end else begin
            rd_a_valid_r <= 1'b0;
        end
    end

    // Port B output registers, same behaviour as port A.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_b_data_r  <= '0;
            rd_b_valid_r <= 1'b0;
            rd_b_err_r   <= 1'b0;
        end else if (bus.RdEn_B) begin
            rd_b_data_r  <= rd_b_data_s;
            rd_b_valid_r <= 1'b1;
            rd_b_err_r   <= !in_range(bus.RdAddr_B);
        end else begin
            rd_b_valid_r <= 1'b0;
        end
    end

    // Flat exposure of the low registers straight from storage.
    always_comb begin
        regs_s = '0;
        for (int i = 0; i < NEXPOSE; i++) regs_s[i*DSIZE +: DSIZE] = mem_r[i];
    end

    assign bus.RdData_A  = rd_a_data_r;
    assign bus.RdValid_A = rd_a_valid_r;
    assign bus.RdErr_A   = rd_a_err_r;
    assign bus.RdData_B  = rd_b_data_r;
    assign bus.RdValid_B = rd_b_valid_r;
    assign bus.RdErr_B   = rd_b_err_r;
    assign bus.REGS      = regs_s;

`ifdef RF_PARITY_EN
    logic [NB-1:0] par_r [DEPTH];
    logic          rd_a_perr_s, rd_b_perr_s;
    logic          rd_a_perr_r, rd_b_perr_r;

    // Parity is recomputed over the whole merged word; ParInj flips selected lanes for fault injection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) par_r[i] <= lane_par(rst_val(i));
        end else if (wr_hit_s) begin
            par_r[bus.WrAddr] <= lane_par(wr_data_s) ^ bus.ParInj;
        end
    end

    // Parity check of the addressed word; out-of-range reads never flag.
    always_comb begin
        if (in_range(bus.RdAddr_A)) rd_a_perr_s = |(par_r[bus.RdAddr_A] ^ lane_par(mem_r[bus.RdAddr_A]));
        else                        rd_a_perr_s = 1'b0;
        if (in_range(bus.RdAddr_B)) rd_b_perr_s = |(par_r[bus.RdAddr_B] ^ lane_par(mem_r[bus.RdAddr_B]));
        else                        rd_b_perr_s = 1'b0;
    end

    // Parity error flags, registered alongside the valid pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_a_perr_r <= 1'b0;
            rd_b_perr_r <= 1'b0;
        end else begin
            if (bus.RdEn_A) rd_a_perr_r <= rd_a_perr_s;
            if (bus.RdEn_B) rd_b_perr_r <= rd_b_perr_s;
        end
    end

    assign bus.RdPErr_A = rd_a_perr_r;
    assign bus.RdPErr_B = rd_b_perr_r;
`endif
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w with DSIZE=16, DEPTH=12 (out-of-range addresses 12..15).
module tb_reg_file_2r1w;
    localparam int DSIZE   = 16;
    localparam int ASIZE   = 4;
    localparam int DEPTH   = 12;
    localparam int NEXPOSE = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_file_2r1w_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NEXPOSE(NEXPOSE)) bus_if ();

    reg_file_2r1w #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(DEPTH), .NEXPOSE(NEXPOSE),
        .RST_VAL2(16'h0081), .RST_VAL3(16'h0020)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
        bus_if.WrEn   = 1'b1;
        bus_if.WrAddr = a;
        bus_if.WrData = d;
        bus_if.WrStrb = s;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.WrEn = 1'b0; bus_if.WrAddr = 4'd0; bus_if.WrData = 16'h0000; bus_if.WrStrb = 2'b00;
        bus_if.RdEn_A = 1'b0; bus_if.RdAddr_A = 4'd0;
        bus_if.RdEn_B = 1'b0; bus_if.RdAddr_B = 4'd0;
`ifdef RF_PARITY_EN
        bus_if.ParInj = 2'b00;
`endif
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_regs",    bus_if.REGS, 64'h0020_0081_0000_0000);
        check("rst_valid_a", bus_if.RdValid_A, 1'b0);
        check("rst_valid_b", bus_if.RdValid_B, 1'b0);
        check("rst_data_a",  bus_if.RdData_A, 16'h0000);
        check("rst_err_a",   bus_if.RdErr_A, 1'b0);

        // Byte strobes
        wr(4'd5, 16'hABCD, 2'b11); tick();
        wr(4'd5, 16'h1234, 2'b01); tick();
        bus_if.WrEn = 1'b0;
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd5; tick();
        bus_if.RdEn_A = 1'b0;
        check("strb_data_a",  bus_if.RdData_A, 16'hAB34);
        check("strb_valid_a", bus_if.RdValid_A, 1'b1);
        check("strb_err_a",   bus_if.RdErr_A, 1'b0);
        tick();
        check("strb_pulse_end", bus_if.RdValid_A, 1'b0);
        check("strb_data_hold", bus_if.RdData_A, 16'hAB34);
        wr(4'd5, 16'h9900, 2'b10); tick();
        wr(4'd0, 16'hFFFF, 2'b00); tick();
        bus_if.WrEn = 1'b0;
        check("strb_zero_noop", bus_if.REGS, 64'h0020_0081_0000_0000);

        // Read-first collision on both ports
        wr(4'd1, 16'h0011, 2'b11); tick();
        wr(4'd1, 16'h0022, 2'b11);
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd1;
        bus_if.RdEn_B = 1'b1; bus_if.RdAddr_B = 4'd1;
        tick();
        bus_if.WrEn = 1'b0; bus_if.RdEn_B = 1'b0;
        check("rf_data_a",  bus_if.RdData_A, 16'h0011);
        check("rf_data_b",  bus_if.RdData_B, 16'h0011);
        check("rf_valid_b", bus_if.RdValid_B, 1'b1);
        tick();
        bus_if.RdEn_A = 1'b0;
        check("rf_next_a",    bus_if.RdData_A, 16'h0022);
        check("rf_valid_a2",  bus_if.RdValid_A, 1'b1);
        check("rf_idle_b",    bus_if.RdValid_B, 1'b0);
        check("rf_hold_b",    bus_if.RdData_B, 16'h0011);
        check("rf_regs",      bus_if.REGS, 64'h0020_0081_0022_0000);

        // Back-to-back reads on B, then last in-range address
        wr(4'd11, 16'h5A5A, 2'b11);
        bus_if.RdEn_B = 1'b1; bus_if.RdAddr_B = 4'd5; tick();
        bus_if.WrEn = 1'b0;
        check("b2b_data_1", bus_if.RdData_B, 16'h9934);
        bus_if.RdAddr_B = 4'd2; tick();
        check("b2b_data_2",  bus_if.RdData_B, 16'h0081);
        check("b2b_valid_2", bus_if.RdValid_B, 1'b1);
        bus_if.RdAddr_B = 4'd11; tick();
        bus_if.RdEn_B = 1'b0;
        check("edge_data_11", bus_if.RdData_B, 16'h5A5A);
        check("edge_err_11",  bus_if.RdErr_B, 1'b0);

        // Out of range
        wr(4'd13, 16'h00FF, 2'b11); tick();
        bus_if.WrEn = 1'b0;
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd13;
        bus_if.RdEn_B = 1'b1; bus_if.RdAddr_B = 4'd12;
        tick();
        bus_if.RdEn_A = 1'b0; bus_if.RdEn_B = 1'b0;
        check("oor_data_a",  bus_if.RdData_A, 16'h0000);
        check("oor_err_a",   bus_if.RdErr_A, 1'b1);
        check("oor_valid_a", bus_if.RdValid_A, 1'b1);
        check("oor_data_b",  bus_if.RdData_B, 16'h0000);
        check("oor_err_b",   bus_if.RdErr_B, 1'b1);
        check("oor_regs",    bus_if.REGS, 64'h0020_0081_0022_0000);
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd5; tick();
        bus_if.RdEn_A = 1'b0;
        check("oor_err_clr", bus_if.RdErr_A, 1'b0);
        check("oor_reg5",    bus_if.RdData_A, 16'h9934);

        // Reset mid-operation
        wr(4'd3, 16'h0055, 2'b11);
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus_if.WrEn = 1'b0; bus_if.RdEn_A = 1'b0;
        check("mid_rst_valid", bus_if.RdValid_A, 1'b0);
        check("mid_rst_data",  bus_if.RdData_A, 16'h0000);
        check("mid_rst_regs",  bus_if.REGS, 64'h0020_0081_0000_0000);
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd5; tick();
        bus_if.RdEn_A = 1'b0;
        check("mid_rst_reg5", bus_if.RdData_A, 16'h0000);

`ifdef RF_PARITY_EN
        // Parity injection and recovery
        check("par_rst", bus_if.RdPErr_A, 1'b0);
        wr(4'd0, 16'h0007, 2'b11); bus_if.ParInj = 2'b01; tick();
        bus_if.WrEn = 1'b0; bus_if.ParInj = 2'b00;
        bus_if.RdEn_A = 1'b1; bus_if.RdAddr_A = 4'd0; tick();
        bus_if.RdEn_A = 1'b0;
        check("par_inj_err",  bus_if.RdPErr_A, 1'b1);
        check("par_inj_data", bus_if.RdData_A, 16'h0007);
        wr(4'd0, 16'h0007, 2'b11); tick();
        bus_if.WrEn = 1'b0;
        bus_if.RdEn_A = 1'b1; bus_if.RdEn_B = 1'b1; bus_if.RdAddr_B = 4'd14; tick();
        bus_if.RdEn_A = 1'b0; bus_if.RdEn_B = 1'b0;
        check("par_clean", bus_if.RdPErr_A, 1'b0);
        check("par_oor_b", bus_if.RdPErr_B, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
